// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter and the benches that drive it.
//   arb_state_e : arbiter state codes
//   gid_w()     : width of the owner index for a given master count
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    OWNED       = 2'd1,
    SPLIT       = 2'd2,
    SPLIT_OWNED = 2'd3
  } arb_state_e;

  // Owner index width; a single master bit is still one bit wide.
  function automatic int gid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : candidate requests (already masked by the caller)
//   last_id : index of the previous grant; search starts just after it
//   valid   : at least one candidate
//   winner  : first candidate strictly after last_id, cyclically
module rr_pick #(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last_id,
  output logic          valid,
  output logic [IW-1:0] winner
);

  logic [2*NM-1:0] rot;
  int              sh;
  int              idx;

  // Rotate so bit 0 is the master right after last_id; the lowest set
  // bit of the rotated vector is then the winner.
  always_comb begin
    sh     = int'(last_id) + 1;
    rot    = {req, req} >> sh;
    valid  = 1'b0;
    idx    = 0;
    winner = '0;
    for (int j = NM - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        idx   = sh + j;
      end
    end
    if (idx >= NM) idx = idx - NM;
    if (idx >= NM) idx = idx - NM;
    winner = IW'(idx);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with single outstanding split transaction.
//   clk, reset    : clock, synchronous active-high reset
//   req[NM]       : level requests, held for the whole transaction
//   hold          : slave asks to split the current transaction
//   grant[NM]     : registered one-hot grant (zero when unowned)
//   grant_id      : index of the owner (0 when unowned)
//   bus_available : registered, low while a second master owns the bus
//                   during a split
//   split_active  : a split is outstanding
//   timeout       : one-cycle pulse on a forced release
// Build option: define ARB_TIMEOUT_EN to bound ownership to TIMEOUT
// granted cycles; otherwise ownership is unbounded and timeout is 0.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NM-1:0]        req,
  input  logic                 hold,
  output logic [NM-1:0]        grant,
  output logic [gid_w(NM)-1:0] grant_id,
  output logic                 bus_available,
  output logic                 split_active,
  output logic                 timeout
);

  localparam int IW = gid_w(NM);

  arb_state_e    state, state_nx;
  logic [NM-1:0] grant_nx;
  logic [IW-1:0] grant_id_nx;
  logic [IW-1:0] last_id, last_id_nx;
  logic [IW-1:0] split_id, split_id_nx;
  logic          split_active_nx;
  logic          expire;
  logic          owner_req;

  logic [NM-1:0] pick_req;
  logic          pick_valid;
  logic [IW-1:0] pick_id;

  // The split master keeps its place; it must not win a second slot.
  assign pick_req  = (state == SPLIT) ? (req & ~(NM'(1) << split_id)) : req;
  assign owner_req = req[grant_id];

  rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req     (pick_req),
    .last_id (last_id),
    .valid   (pick_valid),
    .winner  (pick_id)
  );

  always_comb begin
    state_nx        = state;
    grant_nx        = grant;
    grant_id_nx     = grant_id;
    last_id_nx      = last_id;
    split_id_nx     = split_id;
    split_active_nx = split_active;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx    = OWNED;
          grant_nx    = NM'(1) << pick_id;
          grant_id_nx = pick_id;
          last_id_nx  = pick_id;
        end
      end
      OWNED: begin
        // Hold beats a same-cycle release so the split is never lost.
        if (hold) begin
          state_nx        = SPLIT;
          split_id_nx     = grant_id;
          split_active_nx = 1'b1;
          grant_nx        = '0;
          grant_id_nx     = '0;
        end else if (expire || !owner_req) begin
          state_nx    = IDLE;
          grant_nx    = '0;
          grant_id_nx = '0;
          last_id_nx  = grant_id;
        end
      end
      SPLIT: begin
        if (!hold) begin
          split_active_nx = 1'b0;
          if (req[split_id]) begin
            state_nx    = OWNED;
            grant_nx    = NM'(1) << split_id;
            grant_id_nx = split_id;
            last_id_nx  = split_id;
          end else begin
            state_nx    = IDLE;
            split_id_nx = '0;
          end
        end else if (pick_valid) begin
          state_nx    = SPLIT_OWNED;
          grant_nx    = NM'(1) << pick_id;
          grant_id_nx = pick_id;
          last_id_nx  = pick_id;
        end
      end
      SPLIT_OWNED: begin
        // hold is only looked at once the interim owner lets go.
        if (expire || !owner_req) begin
          grant_nx    = '0;
          grant_id_nx = '0;
          last_id_nx  = grant_id;
          if (hold) begin
            state_nx = SPLIT;
          end else begin
            split_active_nx = 1'b0;
            if (req[split_id]) begin
              state_nx    = OWNED;
              grant_nx    = NM'(1) << split_id;
              grant_id_nx = split_id;
              last_id_nx  = split_id;
            end else begin
              state_nx    = IDLE;
              split_id_nx = '0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      grant_id      <= '0;
      bus_available <= 1'b1;
      split_active  <= 1'b0;
      last_id       <= IW'(NM - 1);
      split_id      <= '0;
    end else begin
      state         <= state_nx;
      grant         <= grant_nx;
      grant_id      <= grant_id_nx;
      bus_available <= (state_nx != SPLIT_OWNED);
      split_active  <= split_active_nx;
      last_id       <= last_id_nx;
      split_id      <= split_id_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] hold_cnt;
  logic          new_grant;

  // hold_cnt is the number of completed granted cycles before this one,
  // so the owner keeps the bus for exactly TIMEOUT cycles.
  assign expire    = ((state == OWNED) || (state == SPLIT_OWNED)) &&
                     (hold_cnt == CW'(TIMEOUT - 1));
  assign new_grant = (state_nx != state) && (|grant_nx);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= expire && !((state == OWNED) && hold);
      if (new_grant || !(|grant_nx)) hold_cnt <= '0;
      else                           hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NM=2, TIMEOUT=8).
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic       hold;
  logic [1:0] grant;
  logic       grant_id;
  logic       bus_available;
  logic       split_active;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.NM(2), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .hold          (hold),
    .grant         (grant),
    .grant_id      (grant_id),
    .bus_available (bus_available),
    .split_active  (split_active),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic       id;
    logic       s;
    logic       b;
    logic       t;
  } exp_t;

  typedef struct packed {
    logic [1:0] rq;
    logic       hd;
    logic [1:0] eg;
    logic       es;
    logic       eb;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[31];

  task automatic check();
    exp_t  e;
    string nm;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: queue empty, got grant=%b", grant);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if ({grant, grant_id, split_active, bus_available, timeout} !==
        {e.g, e.id, e.s, e.b, e.t}) begin
      fails++;
      $display("FAIL %s: got grant=%b id=%b split=%b bav=%b to=%b, expected grant=%b id=%b split=%b bav=%b to=%b",
               nm, grant, grant_id, split_active, bus_available, timeout,
               e.g, e.id, e.s, e.b, e.t);
    end
  endtask

  // Drive one cycle of inputs, expect the registered outputs after the edge.
  task automatic step(input string nm, input logic r, input logic [1:0] rq,
                      input logic hd, input logic [1:0] eg, input logic es,
                      input logic eb, input logic et);
    exp_t e;
    reset = r;
    req   = rq;
    hold  = hd;
    e.g = eg;
    e.id = eg[1];
    e.s = es;
    e.b = eb;
    e.t = et;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got grant=%b", grant);
    $fatal(1, "watchdog");
  end

  initial begin
    //          req    hold  grant  split bav
    tbl[0]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1}; // rr from last_id=1 -> m0
    tbl[1]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1}; // m0 releases: turnaround
    tbl[2]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[3]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[4]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[6]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1}; // last_id=1 -> m0
    tbl[7]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1}; // hold in IDLE ignored
    tbl[10] = '{2'b01, 1'b1, 2'b01, 1'b0, 1'b1}; // IDLE grants despite hold
    tbl[11] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b1}; // split of m0
    tbl[12] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0}; // m1 owns during split
    tbl[13] = '{2'b11, 1'b0, 2'b10, 1'b1, 1'b0}; // hold falls, not sampled
    tbl[14] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1}; // m1 releases, m0 regranted
    tbl[15] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[16] = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[17] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1}; // req falls with hold: split
    tbl[18] = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b1}; // split_id=1 regranted, not rr
    tbl[19] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[20] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[21] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[22] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b1}; // split master masked
    tbl[23] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1}; // split abandoned -> IDLE
    tbl[24] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[25] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[26] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[27] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[28] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b1}; // release with hold -> SPLIT
    tbl[29] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[30] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};

    reset = 1'b1;
    req   = 2'b00;
    hold  = 1'b0;
    step("reset_state", 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 31; i++)
      step($sformatf("vec%0d", i), 1'b0, tbl[i].rq, tbl[i].hd,
           tbl[i].eg, tbl[i].es, tbl[i].eb, 1'b0);

    // Reset while another master owns the bus during a split.
    step("rst_own",    1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    step("rst_split",  1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    step("rst_so",     1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("rst_in_so",  1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    step("rst_regrant",1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    step("rst_done",   1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Ownership bound: both masters keep requesting.
    step("to_reset",   1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      step($sformatf("to_owned%0d", i), 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    step("to_pulse",   1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    step("to_next",    1'b0, 2'b11, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 12; i++)
      step($sformatf("no_to%0d", i), 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
`endif
    step("to_release", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NM, default 2, number of masters (legal 2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles one owner may hold the bus.
REQ-003 Port clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  NM  per-master bus request, level; held high for the whole transaction.
REQ-006 Port hold  input  1  slave split request (slave is in its read-wait).
REQ-007 Port grant  output  NM  one-hot registered grant; all-zero when there is no owner.
REQ-008 Port grant_id  output  max(1,clog2(NM))  index of the current owner; 0 when there is no owner.
REQ-009 Port bus_available  output  1  registered; tells the slave it may return read data.
REQ-010 Port split_active  output  1  a split transaction is outstanding.
REQ-011 Port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-012 The block SHALL use four states: IDLE, OWNED, SPLIT, SPLIT_OWNED.
REQ-013 IDLE: if any req is high, the block SHALL go to OWNED and grant the round-robin winner; grant is high on the next edge (1-cycle latency).
REQ-014 Round-robin: the winner SHALL be the first requester strictly after last_id, searched cyclically; last_id updates on every grant.
REQ-015 OWNED, owner req low: the block SHALL go to IDLE and drop grant next edge; the earliest new grant is one cycle later (one turnaround cycle).
REQ-016 OWNED, hold high: the block SHALL go to SPLIT, set split_id to the owner, drop grant and set split_active.
REQ-017 Hold high and owner req falling in the same cycle: hold SHALL win and the split SHALL be recorded.
REQ-018 SPLIT, hold low and req[split_id] high: the block SHALL go to OWNED, regrant split_id and clear split_active.
REQ-019 SPLIT, hold low and req[split_id] low: the block SHALL go to IDLE and clear the split.
REQ-020 SPLIT, hold high and another master requesting: the block SHALL go to SPLIT_OWNED and grant the round-robin winner, with req[split_id] masked from arbitration.
REQ-021 SPLIT_OWNED, owner releases: the block SHALL go to SPLIT if hold is high; otherwise it SHALL apply REQ-018/019.
REQ-022 The block SHALL support only one outstanding split; hold changes in SPLIT_OWNED SHALL only be sampled when the owner releases.
REQ-023 hold in IDLE SHALL be ignored.
REQ-024 bus_available SHALL be registered as (next state != SPLIT_OWNED).
REQ-025 grant SHALL never have more than one bit set; grant_id SHALL always match grant.

Reset
REQ-026 In reset, the block SHALL set state to IDLE, grant=0, grant_id=0, bus_available=1, split_active=0, timeout=0, last_id=NM-1, split_id=0 and hold_cnt=0.
REQ-027 Reset mid-transaction or mid-split SHALL abandon the split; the reset values SHALL appear on the following edge.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, hold_cnt SHALL count the cycles the current owner is granted (cleared on each grant); at hold_cnt==TIMEOUT the grant SHALL drop, OWNED SHALL go to IDLE, SPLIT_OWNED SHALL go to SPLIT, timeout SHALL pulse and last_id SHALL be set to the owner.
REQ-029 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied to 0 and ownership SHALL be unbounded.

Structure
REQ-030 The state codes and the grant_id width function SHALL live in the shared package bus_arb_pkg, reused by the master and slave benches.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: masked req, last_id; outputs: valid, winner index).

Verification
REQ-032 NM=2, req=2'b11 from IDLE after reset -> grant=01 at +1 cycle; master 0 releases -> grant=00 for one cycle, then grant=10.
REQ-033 Master 0 owns; hold rises at cycle 10 -> grant=00 and split_active=1 at 11; master 1 requesting -> grant=10 and bus_available=0 at 12.
REQ-034 Continuing REQ-033, hold falls while master 1 still owns -> split_active remains 1; master 1 releases -> grant=01, split_active=0 and bus_available=1 the next cycle.
REQ-035 Owner req falls in the same cycle hold rises -> SPLIT is entered and split_id=owner.
REQ-036 ARB_TIMEOUT_EN defined, TIMEOUT=8, master 0 holds req -> grant drops after 8 granted cycles with a one-cycle timeout pulse; master 1 is granted next if requesting.
REQ-037 Reset asserted in SPLIT_OWNED -> all outputs return to their reset values the next edge; a req issued afterwards is granted from IDLE.
